toggle_cover_detect: RTL and testbench

//  Per-bit toggle detector for the toggle-coverage flow. Samples a WIDTH-bit probed signal each cycle
//  and marks a bit covered once it has been seen both rising (0->1) and falling (1->0). Emits a
//  one-cycle pulse per bit on first coverage. That pulse drives the valid vector of the downstream
//  DPI toggle-cover reporter, so each cover index is reported at most once per clear epoch.

---
 rtl/toggle_cover_pkg.sv | 25 ++
 rtl/toggle_cover_bit.sv | 45 ++++
 rtl/toggle_cover_detect.sv | 87 ++++++++
 tb/tb_toggle_cover_detect.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle-coverage detector: FSM state encoding
// and a width-bounded popcount used for the covered-bit count.
package toggle_cover_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Upper bound on the probed width the popcount helper accepts.
    localparam int POP_MAX_W = 1024;

    function automatic int popcount(input logic [POP_MAX_W-1:0] v, input int width);
        int cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (i < width) begin
                cnt = cnt + {31'b0, v[i]};
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/toggle_cover_bit.sv
// One probed bit: remembers whether a rise and a fall have been seen and raises
// a single registered valid pulse the first time both have happened.
module toggle_cover_bit (
    input  logic clock,
    input  logic clear,
    input  logic detect,
    input  logic prev,
    input  logic sig,
    output logic valid,
    output logic covered_next
);

    logic rose;
    logic fell;
    logic covered;
    logic rose_n;
    logic fell_n;
    logic hit;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        rose_n       = rose | (~prev & sig);
        fell_n       = fell | (prev & ~sig);
        hit          = detect & rose_n & fell_n & ~covered;
        covered_next = covered | hit;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) begin
            rose    <= 1'b0;
            fell    <= 1'b0;
            covered <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= hit;
            if (detect) begin
                rose    <= rose_n;
                fell    <= fell_n;
                covered <= covered_next;
            end
        end
    end

endmodule

// File: rtl/toggle_cover_detect.sv
// Per-bit toggle-coverage detector: FSM gating detection, baseline register,
// covered-bit count and the all-covered flag around WIDTH toggle_cover_bit cells.
module toggle_cover_detect
    import toggle_cover_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] valid,
    output logic [CNT_W-1:0] covered_cnt,
    output logic             all_covered
);

    state_t               state;
    logic [WIDTH-1:0]     prev;
    logic [WIDTH-1:0]     covered_next;
    logic [POP_MAX_W-1:0] covered_ext;
    logic [CNT_W-1:0]     next_cnt;
    logic                 next_all;
    logic                 sync_clear;
    logic                 detect;

    // Reset and clear have identical effect, so the bit cells see one combined re-arm.
    assign sync_clear = reset | clear;
    assign detect     = (state == ACTIVE) & enable;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        toggle_cover_bit u_bit (
            .clock        (clock),
            .clear        (sync_clear),
            .detect       (detect),
            .prev         (prev[g]),
            .sig          (sig[g]),
            .valid        (valid[g]),
            .covered_next (covered_next[g])
        );
    end

    always_comb begin
        covered_ext = POP_MAX_W'(covered_next);
        next_cnt    = CNT_W'(popcount(covered_ext, WIDTH));
        next_all    = &covered_next;
    end

    always_ff @(posedge clock) begin
        if (sync_clear) begin
            state       <= IDLE;
            prev        <= '0;
            covered_cnt <= '0;
            all_covered <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Baseline capture only; a change across an enable gap is never an edge.
                    if (enable) begin
                        prev  <= sig;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (enable) begin
                        prev        <= sig;
                        covered_cnt <= next_cnt;
                        all_covered <= next_all;
                        if (next_all) begin
                            state <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Directed bench: stimulus pushes expected valid pulses into a scoreboard queue,
// a negedge monitor pops and compares whenever a pulse is due.
module tb_toggle_cover_detect;
    import toggle_cover_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] v;
        logic [CNT_W-1:0] cnt;
        logic             all;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] sig;
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] valid;
    logic [CNT_W-1:0] covered_cnt;
    logic             all_covered;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   mon_on = 1'b0;
    exp_t q[$];
    exp_t mon_e;

    toggle_cover_detect #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .sig         (sig),
        .enable      (enable),
        .clear       (clear),
        .valid       (valid),
        .covered_cnt (covered_cnt),
        .all_covered (all_covered)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input logic [WIDTH-1:0] s, input logic en, input logic clr, input logic rst);
        sig    = s;
        enable = en;
        clear  = clr;
        reset  = rst;
        @(posedge clock);
        #1;
    endtask

    // Call just before the step whose sampling edge completes the toggle.
    task automatic expect_pulse(input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] cnt, input logic all);
        q.push_back('{due: cyc + 1, v: v, cnt: cnt, all: all});
    endtask

    always @(negedge clock) begin
        if (mon_on) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                check("pulse_missing_due_cycle", 32'(cyc), 32'(q[0].due));
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                mon_e = q.pop_front();
                check("pulse_valid", valid, mon_e.v);
                check("pulse_cnt", 32'(covered_cnt), 32'(mon_e.cnt));
                check("pulse_all", 32'(all_covered), 32'(mon_e.all));
            end else begin
                check("valid_quiet", valid, 32'h0);
            end
        end
    end

    initial begin
        step(32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check("reset_valid", valid, 32'h0);
        check("reset_cnt", 32'(covered_cnt), 32'd0);
        check("reset_all", 32'(all_covered), 32'd0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        mon_on = 1'b1;

        // Bit 0: rise, hold, fall.
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h1, 1'b1, 1'b0, 1'b0);
        step(32'h1, 1'b1, 1'b0, 1'b0);
        step(32'h1, 1'b1, 1'b0, 1'b0);
        expect_pulse(32'h1, 6'd1, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        check("t1_cnt", 32'(covered_cnt), 32'd1);

        // Bit 5 one-cycle glitch, then a repeat that must stay silent.
        step(32'h20, 1'b1, 1'b0, 1'b0);
        expect_pulse(32'h20, 6'd2, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h20, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        check("t2_cnt_unchanged", 32'(covered_cnt), 32'd2);

        // From a fresh epoch, flip every bit at once to reach DONE.
        step(32'h0, 1'b1, 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        expect_pulse(32'hFFFF_FFFF, 6'd32, 1'b1);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        check("t3_cnt", 32'(covered_cnt), 32'd32);
        check("t3_all", 32'(all_covered), 32'd1);
        check("t3_state", 32'(dut.state), 32'(DONE));
        step(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        check("t3_done_sticky", 32'(dut.state), 32'(DONE));
        check("t3_all_sticky", 32'(all_covered), 32'd1);
        step(32'h0, 1'b1, 1'b1, 1'b0);
        check("t3_clear_cnt", 32'(covered_cnt), 32'd0);
        check("t3_clear_all", 32'(all_covered), 32'd0);
        check("t3_clear_state", 32'(dut.state), 32'(IDLE));

        // Change during an enable gap is not an edge; baseline is recaptured as 0xF.
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'hF, 1'b0, 1'b0, 1'b0);
        step(32'hF, 1'b0, 1'b0, 1'b0);
        step(32'hF, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        check("t4_falls_only_cnt", 32'(covered_cnt), 32'd0);
        expect_pulse(32'hF, 6'd4, 1'b0);
        step(32'hF, 1'b1, 1'b0, 1'b0);
        step(32'hF, 1'b1, 1'b0, 1'b0);
        check("t4_cnt", 32'(covered_cnt), 32'd4);

        // Up to seven covered, then clear with enable held high.
        step(32'h7F, 1'b1, 1'b0, 1'b0);
        expect_pulse(32'h70, 6'd7, 1'b0);
        step(32'h0F, 1'b1, 1'b0, 1'b0);
        check("t5_cnt7", 32'(covered_cnt), 32'd7);
        step(32'h0F, 1'b1, 1'b1, 1'b0);
        check("t5_clear_cnt", 32'(covered_cnt), 32'd0);
        check("t5_clear_all", 32'(all_covered), 32'd0);
        check("t5_clear_valid", valid, 32'h0);
        check("t5_clear_state", 32'(dut.state), 32'(IDLE));
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h1, 1'b1, 1'b0, 1'b0);
        expect_pulse(32'h1, 6'd1, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);

        // Reset lands on the edge that would complete bit 3.
        step(32'h8, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b1);
        check("t6_valid", valid, 32'h0);
        check("t6_cnt", 32'(covered_cnt), 32'd0);
        check("t6_all", 32'(all_covered), 32'd0);
        check("t6_state", 32'(dut.state), 32'(IDLE));
        step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        check("t6_cnt_after", 32'(covered_cnt), 32'd0);

        step(32'h0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
